// File: rtl/lfsr_period_checker.sv
// BIST controller for an N-bit LFSR: loads a seed, counts steps until the
// sequence returns to it, and reports period plus maximal/lockup/timeout flags.
module lfsr_period_checker #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [N-1:0] seed_i,
   input  logic [N-1:0] lfsr_data_i,
   input  logic         lfsr_done_i,
   output logic         load_seed_o,
   output logic [N-1:0] seed_data_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [N:0]   period_o,
   output logic         maximal_o,
   output logic         lockup_o,
   output logic         timeout_o
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

   localparam logic [N:0] MAX_P = {1'b0, {N{1'b1}}};
   localparam logic [N:0] TOUT  = {1'b1, {N{1'b0}}};

   state_e       state_q, state_d;
   logic [N:0]   cnt_q, cnt_d;
   logic [N:0]   period_q, period_d;
   logic [N-1:0] seed_q, seed_d;
   logic         maximal_q, maximal_d;
   logic         lockup_q, lockup_d;
   logic         timeout_q, timeout_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         seed_q    <= '0;
         maximal_q <= 1'b0;
         lockup_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         seed_q    <= seed_d;
         maximal_q <= maximal_d;
         lockup_q  <= lockup_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      seed_d    = seed_q;
      maximal_d = maximal_q;
      lockup_d  = lockup_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               seed_d    = seed_i;
               period_d  = '0;
               maximal_d = 1'b0;
               lockup_d  = 1'b0;
               timeout_d = 1'b0;
               // An all-zero seed would lock the LFSR; report it without loading.
               if (seed_i == '0) begin
                  lockup_d = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            // At cnt 0 the LFSR has just loaded the seed, so its compare flag is stale.
            if (cnt_q != '0) begin
               if (lfsr_data_i == '0) begin
                  lockup_d = 1'b1;
                  period_d = cnt_q;
                  state_d  = DONE;
               end else if (lfsr_done_i) begin
                  period_d  = cnt_q;
                  maximal_d = (cnt_q == MAX_P);
                  state_d   = DONE;
               end else if (cnt_q == TOUT) begin
                  timeout_d = 1'b1;
                  period_d  = TOUT;
                  state_d   = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign load_seed_o = (state_q == LOAD);
   assign busy_o      = (state_q == LOAD) || (state_q == RUN);
   assign done_o      = (state_q == DONE);
   assign seed_data_o = seed_q;
   assign period_o    = period_q;
   assign maximal_o   = maximal_q;
   assign lockup_o    = lockup_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Bench for lfsr_period_checker: three widths (3/4/5) driven by behavioural
// maximal-length LFSRs; a queue of expected results is checked on each done.
module tb_lfsr_period_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic st3, st4, st5;
   logic [2:0] sd3;
   logic [3:0] sd4;
   logic [4:0] sd5;

   logic       ld3, bz3, dn3, mx3, lk3, to3;
   logic [2:0] sdat3, l3;
   logic [3:0] per3;
   logic       ld4, bz4, dn4, mx4, lk4, to4;
   logic [3:0] sdat4, l4, d4;
   logic [4:0] per4;
   logic       ld5, bz5, dn5, mx5, lk5, to5;
   logic [4:0] sdat5, l5;
   logic [5:0] per5;

   logic       stuck;
   logic [3:0] stuckv;
   assign d4 = stuck ? stuckv : l4;

   lfsr_period_checker #(.N(3)) u3 (
      .clk_i(clk), .reset_i(rst), .start_i(st3), .seed_i(sd3),
      .lfsr_data_i(l3), .lfsr_done_i(l3 == sdat3),
      .load_seed_o(ld3), .seed_data_o(sdat3), .busy_o(bz3), .done_o(dn3),
      .period_o(per3), .maximal_o(mx3), .lockup_o(lk3), .timeout_o(to3));

   lfsr_period_checker #(.N(4)) u4 (
      .clk_i(clk), .reset_i(rst), .start_i(st4), .seed_i(sd4),
      .lfsr_data_i(d4), .lfsr_done_i(d4 == sdat4),
      .load_seed_o(ld4), .seed_data_o(sdat4), .busy_o(bz4), .done_o(dn4),
      .period_o(per4), .maximal_o(mx4), .lockup_o(lk4), .timeout_o(to4));

   lfsr_period_checker #(.N(5)) u5 (
      .clk_i(clk), .reset_i(rst), .start_i(st5), .seed_i(sd5),
      .lfsr_data_i(l5), .lfsr_done_i(l5 == sdat5),
      .load_seed_o(ld5), .seed_data_o(sdat5), .busy_o(bz5), .done_o(dn5),
      .period_o(per5), .maximal_o(mx5), .lockup_o(lk5), .timeout_o(to5));

   // Fibonacci LFSRs with primitive feedback: periods 7, 15, 31.
   always @(posedge clk) begin
      if (rst) begin
         l3 <= '0; l4 <= '0; l5 <= '0;
      end else begin
         l3 <= ld3 ? sdat3 : {l3[1:0], l3[2] ^ l3[1]};
         l4 <= ld4 ? sdat4 : {l4[2:0], l4[3] ^ l4[2]};
         l5 <= ld5 ? sdat5 : {l5[3:0], l5[4] ^ l5[2]};
      end
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ld_n[3];

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int id; int per; int mx; int lk; int to; int sd; int cyc; int loads;
   } exp_t;
   exp_t q[$];

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic got(int id, int per, int mx, int lk, int to, int sd);
      exp_t e;
      if (q.size() == 0) begin
         total++; bad++;
         $display("FAIL unexpected_done: dut %0d raised done, none expected", id);
         return;
      end
      e = q.pop_front();
      chk("done_dut", id, e.id);
      chk($sformatf("period[%0d]", id), per, e.per);
      chk($sformatf("maximal[%0d]", id), mx, e.mx);
      chk($sformatf("lockup[%0d]", id), lk, e.lk);
      chk($sformatf("timeout[%0d]", id), to, e.to);
      chk($sformatf("seed_data[%0d]", id), sd, e.sd);
      chk($sformatf("done_cycle[%0d]", id), cyc, e.cyc);
      chk($sformatf("load_pulses[%0d]", id), ld_n[id], e.loads);
      ld_n[id] = 0;
   endtask

   always @(negedge clk) begin
      if (rst) ld_n = '{0, 0, 0};
      else begin
         if (ld3) ld_n[0]++;
         if (ld4) ld_n[1]++;
         if (ld5) ld_n[2]++;
      end
      if (dn3) got(0, 32'(per3), 32'(mx3), 32'(lk3), 32'(to3), 32'(sdat3));
      if (dn4) got(1, 32'(per4), 32'(mx4), 32'(lk4), 32'(to4), 32'(sdat4));
      if (dn5) got(2, 32'(per5), 32'(mx5), 32'(lk5), 32'(to5), 32'(sdat5));
   end

   // Returns one cycle after the accepting edge (edge 0), i.e. in cycle 1.
   task automatic go(int id, int sd, bit push, int per, int mx, int lk, int to);
      exp_t e;
      case (id)
         0: begin st3 = 1'b1; sd3 = 3'(sd); end
         1: begin st4 = 1'b1; sd4 = 4'(sd); end
         default: begin st5 = 1'b1; sd5 = 5'(sd); end
      endcase
      @(posedge clk); #1;
      st3 = 1'b0; st4 = 1'b0; st5 = 1'b0;
      if (push) begin
         e.id = id; e.per = per; e.mx = mx; e.lk = lk; e.to = to; e.sd = sd;
         e.cyc   = (sd == 0) ? cyc : cyc + per + 2;
         e.loads = (sd == 0) ? 0 : 1;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk); n++;
      end
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero4(string tag);
      chk({tag, "_load"}, 32'(ld4), 0);
      chk({tag, "_seed_data"}, 32'(sdat4), 0);
      chk({tag, "_busy"}, 32'(bz4), 0);
      chk({tag, "_done"}, 32'(dn4), 0);
      chk({tag, "_period"}, 32'(per4), 0);
      chk({tag, "_flags"}, 32'({mx4, lk4, to4}), 0);
   endtask

   initial begin
      rst = 1'b1;
      st3 = 1'b0; st4 = 1'b0; st5 = 1'b0;
      sd3 = '0; sd4 = '0; sd5 = '0;
      stuck = 1'b0; stuckv = '0;
      repeat (3) @(posedge clk); #1;
      chk_zero4("reset");
      chk("reset_others", 32'({ld3, bz3, dn3, ld5, bz5, dn5}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      go(1, 1, 1'b1, 15, 1, 0, 0);
      chk("load_in_cycle1", 32'(ld4), 1);
      chk("busy_in_load", 32'(bz4), 1);
      @(posedge clk); #1;
      chk("load_in_cycle2", 32'(ld4), 0);
      chk("busy_in_run", 32'(bz4), 1);
      drain();
      chk("busy_after_done", 32'(bz4), 0);

      go(1, 0, 1'b1, 0, 0, 1, 0);
      chk("busy_zero_seed", 32'(bz4), 0);
      drain();

      go(0, 5, 1'b1, 7, 1, 0, 0);
      drain();
      go(2, 31, 1'b1, 31, 1, 0, 0);
      drain();
      go(1, 15, 1'b1, 15, 1, 0, 0);
      drain();

      stuck = 1'b1; stuckv = 4'h9;
      go(1, 3, 1'b1, 16, 0, 0, 1);
      drain();
      stuckv = 4'h0;
      go(1, 6, 1'b1, 1, 0, 1, 0);
      drain();
      stuck = 1'b0;

      go(1, 2, 1'b1, 15, 1, 0, 0);
      repeat (4) @(posedge clk); #1;
      st4 = 1'b1; sd4 = 4'hA;
      @(posedge clk); #1;
      st4 = 1'b0;
      chk("seed_hold_1", 32'(sdat4), 2);
      repeat (4) @(posedge clk); #1;
      st4 = 1'b1; sd4 = 4'h7;
      @(posedge clk); #1;
      st4 = 1'b0;
      chk("seed_hold_2", 32'(sdat4), 2);
      drain();

      go(1, 5, 1'b0, 0, 0, 0, 0);
      repeat (8) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_zero4("midrun_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      go(1, 8, 1'b1, 15, 1, 0, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
